// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: commits the MEM/WB bundle on the rising edge
// and serves combinational read ports with optional same-cycle write bypass.
module wb_regfile #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 4,
    parameter int                NREGS     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit                BYPASS    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memToReg,
    input  logic [1:0]        regWrite,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] memReadout,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] r0Result,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    output logic [DATA_W-1:0] r0Data,
    output logic [DATA_W-1:0] wbData,
    output logic              wbValid,
    output logic [15:0]       wbCount
);

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_RD   = 2'b01;
    localparam logic [1:0] WR_DUAL = 2'b10;
    localparam logic [1:0] WR_R0   = 2'b11;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wb_valid_q, wb_valid_d;
    logic [15:0]       wb_count_q, wb_count_d;
    logic              wr_rd, wr_r0, commit;

    assign wbData = memToReg ? memReadout : aluResult;

    always_comb begin
        wr_rd  = (regWrite == WR_RD) || (regWrite == WR_DUAL);
        wr_r0  = (regWrite == WR_DUAL) || (regWrite == WR_R0);
        commit = (regWrite != WR_NONE);
    end

    // The R0 write is applied last so it wins when a dual write also targets R0.
    always_comb begin
        regs_d = regs_q;
        if (wr_rd) begin
            regs_d[wbAddr] = wbData;
        end
        if (wr_r0) begin
            regs_d[0] = r0Result;
        end
    end

    always_comb begin
        wb_valid_d = commit;
        wb_count_d = wb_count_q + {15'd0, commit};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wb_valid_q <= 1'b0;
            wb_count_q <= 16'd0;
        end else begin
            regs_q     <= regs_d;
            wb_valid_q <= wb_valid_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Bypass is suppressed during reset so reads reflect what is actually stored.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = regs_q[addr];
        if (BYPASS && reset) begin
            if (wr_r0 && (addr == '0)) begin
                value = r0Result;
            end else if (wr_rd && (addr == wbAddr)) begin
                value = wbData;
            end
        end
        return value;
    endfunction

    always_comb begin
        rdDataA = read_port(rdAddrA);
        rdDataB = read_port(rdAddrB);
        r0Data  = read_port('0);
    end

    assign wbValid = wb_valid_q;
    assign wbCount = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile; a bypassing and a non-bypassing instance share stimulus
// and are checked against an array-based model of the architectural state.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        memToReg;
    logic [1:0]  regWrite;
    logic [3:0]  wbAddr;
    logic [15:0] memReadout, aluResult, r0Result;
    logic [3:0]  rdAddrA, rdAddrB;
    logic [15:0] rdDataA, rdDataB, r0Data, wbData;
    logic        wbValid;
    logic [15:0] wbCount;
    logic [15:0] nb_rdDataA, nb_rdDataB, nb_r0Data, nb_wbData;
    logic        nb_wbValid;
    logic [15:0] nb_wbCount;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ref_regs [16];
    logic        ref_valid;
    logic [15:0] ref_count;

    always #5 clk = ~clk;

    wb_regfile #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .memToReg(memToReg), .regWrite(regWrite), .wbAddr(wbAddr),
        .memReadout(memReadout), .aluResult(aluResult), .r0Result(r0Result),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
        .r0Data(r0Data), .wbData(wbData), .wbValid(wbValid), .wbCount(wbCount)
    );

    wb_regfile #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .memToReg(memToReg), .regWrite(regWrite), .wbAddr(wbAddr),
        .memReadout(memReadout), .aluResult(aluResult), .r0Result(r0Result),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(nb_rdDataA), .rdDataB(nb_rdDataB),
        .r0Data(nb_r0Data), .wbData(nb_wbData), .wbValid(nb_wbValid), .wbCount(nb_wbCount)
    );

    // Value a register holds once the pending write (if any) has been committed.
    function automatic logic [15:0] after_commit(input logic [3:0] a);
        logic [15:0] v;
        v = ref_regs[a];
        if (regWrite == 2'b01 || regWrite == 2'b10) begin
            if (a == wbAddr) v = memToReg ? memReadout : aluResult;
        end
        if (regWrite == 2'b10 || regWrite == 2'b11) begin
            if (a == 4'd0) v = r0Result;
        end
        return v;
    endfunction

    // Expected read: bypassing port sees post-commit value, otherwise the stored one.
    function automatic logic [15:0] exp_read(input logic [3:0] a, input bit byp);
        if (byp && reset) return after_commit(a);
        return ref_regs[a];
    endfunction

    task automatic drive(input logic [1:0] rw, input logic [3:0] a, input logic m2r,
                         input logic [15:0] mem, input logic [15:0] alu, input logic [15:0] r0,
                         input logic [3:0] ra, input logic [3:0] rb);
        @(negedge clk);
        regWrite = rw; wbAddr = a; memToReg = m2r;
        memReadout = mem; aluResult = alu; r0Result = r0;
        rdAddrA = ra; rdAddrB = rb;
        #1;
    endtask

    task automatic tick();
        logic [15:0] nxt [16];
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 16; i++) nxt[i] = 16'h0000;
            ref_valid = 1'b0;
            ref_count = 16'h0000;
        end else begin
            for (int i = 0; i < 16; i++) nxt[i] = after_commit(4'(i));
            ref_valid = (regWrite != 2'b00);
            ref_count = ref_count + ((regWrite != 2'b00) ? 16'd1 : 16'd0);
        end
        ref_regs = nxt;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'($urandom_range(1, 3)), 4'($urandom), 1'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 4'd0, 4'd0);
            tick();
        end
        reset = 1'b0;
        drive(2'b01, 4'd5, 1'b0, 16'h1111, 16'h2222, 16'h3333, 4'd5, 4'd0);
        vectors++;
        if (rdDataA !== ref_regs[5]) begin
            miscompares++;
            $display("FAIL reset_no_bypass: rdDataA=%h expected %h", rdDataA, ref_regs[5]);
        end
        tick();
        reset = 1'b1;
        drive(2'b00, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            rdAddrA = 4'(i); rdAddrB = 4'(15 - i);
            #1;
            vectors++;
            if (rdDataA !== 16'h0000 || rdDataB !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_regs[%0d]: A=%h B=%h expected 0000", i, rdDataA, rdDataB);
            end
        end
        vectors++;
        if (wbValid !== 1'b0 || wbCount !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_status: wbValid=%b wbCount=%h expected 0/0000", wbValid, wbCount);
        end
        $display("test_reset done");
    endtask

    task automatic test_write_mux();
        logic [15:0] exp_d [2];
        exp_d[0] = 16'h1234; exp_d[1] = 16'hBEEF;
        for (int m = 0; m < 2; m++) begin
            drive(2'b01, 4'd5, 1'(m), 16'hBEEF, 16'h1234, 16'h0000, 4'd1, 4'd2);
            vectors++;
            if (wbData !== exp_d[m]) begin
                miscompares++;
                $display("FAIL wb_data_mux m2r=%0d: wbData=%h expected %h", m, wbData, exp_d[m]);
            end
            tick();
            drive(2'b00, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd5, 4'd5);
            vectors++;
            if (rdDataA !== exp_d[m] || wbValid !== 1'b1) begin
                miscompares++;
                $display("FAIL write_rd5 m2r=%0d: reg5=%h wbValid=%b expected %h/1",
                         m, rdDataA, wbValid, exp_d[m]);
            end
        end
        vectors++;
        if (wbCount !== 16'd2) begin
            miscompares++;
            $display("FAIL write_count: wbCount=%0d expected 2", wbCount);
        end
        tick();
        vectors++;
        if (wbValid !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_pulse: wbValid=%b expected 0", wbValid);
        end
        $display("test_write_mux done");
    endtask

    task automatic test_dual();
        logic [15:0] cnt0;
        cnt0 = ref_count;
        drive(2'b10, 4'd3, 1'b0, 16'h0, 16'h00AA, 16'h0055, 4'd3, 4'd0);
        tick();
        drive(2'b00, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd3, 4'd0);
        vectors++;
        if (rdDataA !== 16'h00AA || rdDataB !== 16'h0055 || r0Data !== 16'h0055
            || wbCount !== cnt0 + 16'd1) begin
            miscompares++;
            $display("FAIL dual_write: r3=%h r0=%h r0Data=%h cnt=%h expected 00aa/0055/0055/%h",
                     rdDataA, rdDataB, r0Data, wbCount, cnt0 + 16'd1);
        end
        drive(2'b10, 4'd0, 1'b0, 16'h0, 16'h7777, 16'h0055, 4'd0, 4'd1);
        vectors++;
        if (rdDataA !== 16'h0055 || r0Data !== 16'h0055) begin
            miscompares++;
            $display("FAIL dual_r0_bypass: A=%h r0Data=%h expected 0055", rdDataA, r0Data);
        end
        tick();
        drive(2'b00, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd1);
        vectors++;
        if (rdDataA !== 16'h0055 || wbCount !== cnt0 + 16'd2) begin
            miscompares++;
            $display("FAIL dual_r0_wins: r0=%h cnt=%h expected 0055/%h", rdDataA, wbCount, cnt0 + 16'd2);
        end
        $display("test_dual done");
    endtask

    task automatic test_bypass();
        logic [15:0] old7, old0;
        old7 = ref_regs[7];
        drive(2'b01, 4'd7, 1'b0, 16'h0, 16'hCAFE, 16'h0, 4'd7, 4'd0);
        vectors++;
        if (rdDataA !== 16'hCAFE || nb_rdDataA !== old7) begin
            miscompares++;
            $display("FAIL bypass_rd: A=%h nbA=%h expected cafe/%h", rdDataA, nb_rdDataA, old7);
        end
        tick();
        old0 = ref_regs[0];
        drive(2'b11, 4'd7, 1'b1, 16'h9999, 16'h8888, 16'h4321, 4'd7, 4'd0);
        vectors++;
        if (rdDataB !== 16'h4321 || r0Data !== 16'h4321 || rdDataA !== 16'hCAFE
            || nb_rdDataB !== old0 || nb_r0Data !== old0) begin
            miscompares++;
            $display("FAIL bypass_r0: B=%h r0=%h A=%h nbB=%h nbR0=%h expected 4321/4321/cafe/%h/%h",
                     rdDataB, r0Data, rdDataA, nb_rdDataB, nb_r0Data, old0, old0);
        end
        tick();
        drive(2'b00, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd7, 4'd0);
        vectors++;
        if (nb_rdDataA !== 16'hCAFE || nb_rdDataB !== 16'h4321) begin
            miscompares++;
            $display("FAIL nobypass_after_edge: A=%h B=%h expected cafe/4321", nb_rdDataA, nb_rdDataB);
        end
        $display("test_bypass done");
    endtask

    task automatic test_idle_z();
        logic [15:0] cnt0;
        cnt0 = ref_count;
        drive(2'b00, 4'bzzzz, 1'bz, 16'hzzzz, 16'hzzzz, 16'hzzzz, 4'd5, 4'd0);
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            rdAddrA = 4'(i);
            #1;
            vectors++;
            if (rdDataA !== ref_regs[i]) begin
                miscompares++;
                $display("FAIL idle_z reg%0d: %h expected %h", i, rdDataA, ref_regs[i]);
            end
        end
        vectors++;
        if (wbValid !== 1'b0 || wbCount !== cnt0) begin
            miscompares++;
            $display("FAIL idle_z_status: wbValid=%b cnt=%h expected 0/%h", wbValid, wbCount, cnt0);
        end
        $display("test_idle_z done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(2'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 4'($urandom), 4'($urandom));
            vectors++;
            if (rdDataA !== exp_read(rdAddrA, 1'b1) || rdDataB !== exp_read(rdAddrB, 1'b1)
                || r0Data !== exp_read(4'd0, 1'b1) || nb_rdDataA !== exp_read(rdAddrA, 1'b0)
                || nb_rdDataB !== exp_read(rdAddrB, 1'b0)) begin
                miscompares++;
                $display("FAIL random_read n=%0d rw=%b: A=%h B=%h R0=%h nbA=%h nbB=%h expected %h %h %h %h %h",
                         n, regWrite, rdDataA, rdDataB, r0Data, nb_rdDataA, nb_rdDataB,
                         exp_read(rdAddrA, 1'b1), exp_read(rdAddrB, 1'b1), exp_read(4'd0, 1'b1),
                         exp_read(rdAddrA, 1'b0), exp_read(rdAddrB, 1'b0));
            end
            tick();
            vectors++;
            if (wbValid !== ref_valid || wbCount !== ref_count || nb_wbCount !== ref_count) begin
                miscompares++;
                $display("FAIL random_status n=%0d: valid=%b cnt=%h nbcnt=%h expected %b/%h",
                         n, wbValid, wbCount, nb_wbCount, ref_valid, ref_count);
            end
        end
        $display("test_random done");
    endtask

    task automatic test_wrap();
        reset = 1'b0;
        drive(2'b00, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0);
        tick();
        reset = 1'b1;
        drive(2'b01, 4'd9, 1'b0, 16'h0, 16'h5A5A, 16'h0, 4'd9, 4'd0);
        for (int n = 0; n < 65535; n++) tick();
        vectors++;
        if (wbCount !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: wbCount=%h expected ffff", wbCount);
        end
        tick();
        vectors++;
        if (wbCount !== 16'h0000 || wbValid !== 1'b1 || ref_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap: wbCount=%h wbValid=%b expected 0000/1", wbCount, wbValid);
        end
        $display("test_wrap done");
    endtask

    initial begin
        reset = 1'b0;
        regWrite = 2'b00; wbAddr = 4'd0; memToReg = 1'b0;
        memReadout = 16'h0; aluResult = 16'h0; r0Result = 16'h0;
        rdAddrA = 4'd0; rdAddrB = 4'd0;
        for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0000;
        ref_valid = 1'b0;
        ref_count = 16'h0000;
        tick();
        tick();
        reset = 1'b1;
        test_reset();
        test_write_mux();
        test_dual();
        test_bypass();
        test_idle_z();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage and architectural register file for the 16-bit pipelined CPU. Consumes the control and data bundle launched by the MEM/WB pipeline register on the falling clock edge. Commits results on the following rising edge and serves the decode stage's combinational read ports with same-cycle write bypass. Also handles the dual-destination write used by multiply/divide, where the secondary result goes to R0.

Parameters:
DATA_W, 16, register and datapath width
ADDR_W, 4, register index width
NREGS, 16, number of architectural registers (2**ADDR_W)
RESET_VAL, 16'h0000, value loaded into every register on reset
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only

Ports:
clk  input  1  clock; commits on rising edge
reset  input  1  reset, synchronous, active-low
memToReg  input  1  1 = primary write data is memReadout; 0 = aluResult
regWrite  input  2  00 none, 01 write Rd, 10 write Rd and R0, 11 write R0 only
wbAddr  input  ADDR_W  destination register Rd
memReadout  input  DATA_W  load data from MEM/WB
aluResult  input  DATA_W  ALU result from MEM/WB
r0Result  input  DATA_W  secondary result (remainder or high product) destined for R0
rdAddrA  input  ADDR_W  read port A index
rdAddrB  input  ADDR_W  read port B index
rdDataA  output  DATA_W  read port A data, combinational
rdDataB  output  DATA_W  read port B data, combinational
r0Data  output  DATA_W  dedicated R0 read, combinational
wbData  output  DATA_W  selected primary write-back value, combinational, for forwarding
wbValid  output  1  registered; 1 for one cycle after any committed write
wbCount  output  16  registered count of committed write events

Behaviour:
- Reset is sampled on the rising edge while low:
  - all NREGS registers <= RESET_VAL; wbValid <= 0; wbCount <= 0.
  - Writes presented in that cycle are discarded.
  - Reset has priority over any write.
- Primary data: wbData = memToReg ? memReadout : aluResult. Combinational.
- Commit on rising edge when reset is high:
  - 00: no change; wbValid <= 0.
  - 01: reg[wbAddr] <= wbData.
  - 10: reg[wbAddr] <= wbData and reg[0] <= r0Result in the same edge. If wbAddr == 0, R0 takes r0Result; the R0 write wins.
  - 11: reg[0] <= r0Result only; wbAddr and memToReg are ignored.
- wbValid <= 1 for regWrite != 00, else 0.
- wbCount increments by 1 per committed event. A dual write counts once. The counter wraps from 16'hFFFF to 0.
- Latency:
  - Inputs become stable about half a cycle after the MEM/WB falling edge.
  - Data is visible in the stored array from the next rising edge.
  - With BYPASS = 1, it is visible immediately on the read ports.
- Read ports: rdDataX = reg[rdAddrX], subject to the bypass rules below when BYPASS = 1.
- Bypass priority for port X, highest first:
  1. regWrite in {10, 11} and rdAddrX == 0 -> r0Result.
  2. regWrite in {01, 10} and rdAddrX == wbAddr -> wbData.
  3. Otherwise, the stored value.
- r0Data follows the same R0 bypass rules: primary bypass when regWrite = 01 and wbAddr == 0.
- During reset, read ports return stored contents. No bypass is applied while reset is low.
- R0 is a normal writable register, not hardwired zero.
- X or Z inputs with regWrite = 00 must not corrupt state. The idle pattern from MEM/WB drives high-Z on data.

Test Plan:
- Reset low for one edge after random writes -> all 16 regs read 16'h0000, wbValid = 0, wbCount = 0; a regWrite = 01 in the reset cycle is not committed.
- regWrite = 01, wbAddr = 5, memToReg = 0, aluResult = 16'h1234, memReadout = 16'hBEEF -> after edge reg5 = 16'h1234; repeat with memToReg = 1 -> reg5 = 16'hBEEF; wbValid pulses high, wbCount = 2.
- regWrite = 10, wbAddr = 3, aluResult = 16'h00AA, r0Result = 16'h0055 -> reg3 = 16'h00AA, R0 = 16'h0055, wbCount +1; same with wbAddr = 0 -> R0 = 16'h0055.
- Bypass: regWrite = 01, wbAddr = 7, aluResult = 16'hCAFE, rdAddrA = 7, rdAddrB = 0 with regWrite = 11, r0Result = 16'h4321 -> rdDataA = 16'hCAFE before the edge. Next cycle, rdDataB = 16'h4321 and r0Data = 16'h4321 before the edge. With BYPASS = 0, the old values are returned until the edge.
- regWrite = 00, memReadout = 16'hzzzz, wbAddr = 16'hz -> no register change, wbValid = 0, wbCount unchanged.
- Preload wbCount to 16'hFFFF via 65535 writes, then one more write -> wbCount = 16'h0000, wbValid = 1.
